// File: rtl/vga_console_writer.sv
// Byte-stream terminal front end driving the vga_ctl3 character-memory write port.
// Latency: one cycle from byte acceptance to registered char_we; clear-screen sweep takes ROWS*COLUMNS cycles.
// Backpressure: in_ready is low for the whole clear sweep; bytes are otherwise accepted every cycle.
module vga_console_writer #(
  parameter int COLUMNS = 80,
  parameter int ROWS    = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        char_we,
  output logic [11:0] char_addr,
  output logic [31:0] char_value,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  localparam logic [6:0] COL_LAST = 7'(COLUMNS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_FF = 8'h0C;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state_q, state_d;
  logic [6:0]  sweep_col_q, sweep_col_d;
  logic [4:0]  sweep_row_q, sweep_row_d;
  logic [7:0]  char_byte_q, char_byte_d;
  logic        char_we_d;
  logic [11:0] char_addr_d;
  logic [6:0]  cursor_col_d;
  logic [4:0]  cursor_row_d;
  logic        busy_d;

  logic        accept;
  logic        printable;
  logic [4:0]  row_inc;
  logic [6:0]  base_col, next_col;
  logic [4:0]  base_row, next_row;
  logic        base_last;

  assign in_ready   = (state_q == IDLE);
  assign accept     = in_valid && in_ready;
  assign printable  = (in_data >= 8'h20) && (in_data <= 8'h7E);
  assign row_inc    = (cursor_row == ROW_LAST) ? 5'd0 : cursor_row + 5'd1;
  assign char_value = {24'h0, char_byte_q};

  // The sweep address being written this cycle: (0,0) when the sweep starts from IDLE.
  assign base_col  = (state_q == CLEAR) ? sweep_col_q : 7'd0;
  assign base_row  = (state_q == CLEAR) ? sweep_row_q : 5'd0;
  assign base_last = (base_col == COL_LAST) && (base_row == ROW_LAST);
  assign next_col  = (base_col == COL_LAST) ? 7'd0 : base_col + 7'd1;
  assign next_row  = (base_col == COL_LAST) ? base_row + 5'd1 : base_row;

  always_comb begin
    state_d      = state_q;
    sweep_col_d  = sweep_col_q;
    sweep_row_d  = sweep_row_q;
    char_we_d    = 1'b0;
    char_addr_d  = char_addr;
    char_byte_d  = char_byte_q;
    cursor_col_d = cursor_col;
    cursor_row_d = cursor_row;
    busy_d       = busy;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (printable) begin
            char_we_d   = 1'b1;
            char_addr_d = {cursor_row, cursor_col};
            char_byte_d = in_data;
            if (cursor_col == COL_LAST) begin
              cursor_col_d = 7'd0;
              cursor_row_d = row_inc;
            end else begin
              cursor_col_d = cursor_col + 7'd1;
            end
          end else begin
            case (in_data)
              ASCII_CR: cursor_col_d = 7'd0;
              ASCII_LF: begin
                cursor_col_d = 7'd0;
                cursor_row_d = row_inc;
              end
              ASCII_BS: begin
                if (cursor_col != 7'd0) begin
                  cursor_col_d = cursor_col - 7'd1;
                  char_we_d    = 1'b1;
                  char_addr_d  = {cursor_row, cursor_col - 7'd1};
                  char_byte_d  = ASCII_SP;
                end
              end
              ASCII_FF: begin
                char_we_d    = 1'b1;
                char_addr_d  = 12'd0;
                char_byte_d  = ASCII_SP;
                cursor_col_d = 7'd0;
                cursor_row_d = 5'd0;
                sweep_col_d  = next_col;
                sweep_row_d  = next_row;
                // A 1x1 screen is fully cleared by this single write.
                if (!base_last) begin
                  state_d = CLEAR;
                  busy_d  = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end
      CLEAR: begin
        char_we_d   = 1'b1;
        char_addr_d = {sweep_row_q, sweep_col_q};
        char_byte_d = ASCII_SP;
        sweep_col_d = next_col;
        sweep_row_d = next_row;
        if (base_last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sweep_col_q <= 7'd0;
      sweep_row_q <= 5'd0;
      char_byte_q <= 8'd0;
      char_we     <= 1'b0;
      char_addr   <= 12'd0;
      cursor_col  <= 7'd0;
      cursor_row  <= 5'd0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_col_q <= sweep_col_d;
      sweep_row_q <= sweep_row_d;
      char_byte_q <= char_byte_d;
      char_we     <= char_we_d;
      char_addr   <= char_addr_d;
      cursor_col  <= cursor_col_d;
      cursor_row  <= cursor_row_d;
      busy        <= busy_d;
    end
  end

endmodule
